// File: rtl/regfile_dump.sv
// regfile_dump: debug reader that walks registers FIRST_REG..LAST_REG through a
// spare register-file read port and emits each value on a valid/ready stream,
// tagged with its register index.
//
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   start           : request a dump (sampled only in IDLE)
//   busy            : high from the cycle after start is accepted until done
//   done            : one-cycle pulse after the last word's handshake
//   rf_r_address    : read address to the register file (current read pointer)
//   rf_r_data       : registered read data (valid the cycle after the address)
//   m_data/m_index/m_last/m_valid/m_ready : output word stream
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_r_address,
  input  logic [31:0] rf_r_data,
  output logic [31:0] m_data,
  output logic [4:0]  m_index,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready
);

  if (LAST_REG < FIRST_REG || FIRST_REG < 0 || LAST_REG > 31) begin : g_bad_range
    $error("regfile_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_ptr_q, rd_ptr_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] m_data_q, m_data_d;
  logic [4:0]  m_index_q, m_index_d;
  logic        m_last_q, m_last_d;
  logic        m_valid_q, m_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic hs;
  logic capture;

  // hs: current word leaves at this edge. A new word may be captured on the
  // same edge, which keeps the stream at one word per two cycles.
  assign hs      = m_valid_q && m_ready;
  assign capture = (state_q == S_RUN) && data_ok_q && (!m_valid_q || m_ready);

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    data_ok_d = data_ok_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (hs) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rd_ptr_d  = FIRST;
          data_ok_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_FILL;
        end
      end
      // Address has been presented; data shows up after the next edge.
      S_FILL: begin
        data_ok_d = 1'b1;
        state_d   = S_RUN;
      end
      // Waits here under backpressure with rd_ptr held, so rf_r_data keeps
      // tracking the same register.
      S_RUN: begin
        if (capture) begin
          m_data_d  = rf_r_data;
          m_index_d = rd_ptr_q;
          m_last_d  = (rd_ptr_q == LAST);
          m_valid_d = 1'b1;
          if (rd_ptr_q == LAST) begin
            state_d = S_DRAIN;
          end else begin
            rd_ptr_d  = rd_ptr_q + 5'd1;
            data_ok_d = 1'b0;
            state_d   = S_FILL;
          end
        end
      end
      S_DRAIN: begin
        if (hs) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= FIRST;
      data_ok_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      data_ok_q <= data_ok_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rf_r_address = rd_ptr_q;
  assign m_data       = m_data_q;
  assign m_index      = m_index_q;
  assign m_last       = m_last_q;
  assign m_valid      = m_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: full range 0..31
  logic        reset_n, start, m_ready;
  logic        busy, done, m_last, m_valid;
  logic [4:0]  rf_r_address, m_index;
  logic [31:0] rf_r_data, m_data;
  logic [31:0] mem [32];

  // second instance: single register 10
  logic        start2, m_ready2;
  logic        busy2, done2, m_last2, m_valid2;
  logic [4:0]  rf_r_address2, m_index2;
  logic [31:0] rf_r_data2, m_data2;
  logic [31:0] mem2 [32];

  // register-file read port model: address sampled at an edge, data after it
  always @(posedge clk) rf_r_data  <= mem[rf_r_address];
  always @(posedge clk) rf_r_data2 <= mem2[rf_r_address2];

  regfile_dump #(.FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rf_r_address(rf_r_address), .rf_r_data(rf_r_data),
    .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  regfile_dump #(.FIRST_REG(10), .LAST_REG(10)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .rf_r_address(rf_r_address2), .rf_r_data(rf_r_data2),
    .m_data(m_data2), .m_index(m_index2), .m_last(m_last2),
    .m_valid(m_valid2), .m_ready(m_ready2)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: a dump is the registers 0..31 in order, valued as the model holds them
  task automatic push_dump();
    for (int i = 0; i < 32; i++)
      exp_q.push_back(word_t'{idx: 5'(i), data: mem[i], last: (i == 31)});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // monitor / scoreboard
  logic        hold_v = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_idx, hold_addr;
  logic        hold_last;
  word_t       mon_w;

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        done_cnt++;
        check("done_with_busy", busy, 0);
      end
      if (hold_v && m_valid) begin
        check("hold_data", m_data, hold_data);
        check("hold_index", m_index, hold_idx);
        check("hold_last", m_last, hold_last);
        check("hold_addr", rf_r_address, hold_addr);
      end
      hold_v    = m_valid && !m_ready;
      hold_data = m_data;
      hold_idx  = m_index;
      hold_last = m_last;
      hold_addr = rf_r_address;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: index %0d data 0x%08h with nothing expected", m_index, m_data);
        end else begin
          mon_w = exp_q.pop_front();
          check("word_index", m_index, mon_w.idx);
          check("word_data", m_data, mon_w.data);
          check("word_last", m_last, mon_w.last);
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, dc, w2, d2;
    reset_n = 1'b0; start = 1'b0; m_ready = 1'b1;
    start2 = 1'b0; m_ready2 = 1'b1;
    mem[0] = '0;
    for (int i = 1; i < 32; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 32; i++) mem2[i] = $urandom;
    mem2[10] = 32'hDEADBEEF;
    tick(); tick();

    // reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", rf_r_address, 0);
    reset_n = 1'b1;
    tick();

    // full dump with m_ready=1, latency from the accepting edge E0
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!m_valid && n < 10) begin tick(); n++; end
    check("first_valid_latency", cyc - c0, 2);
    wait_done(100);
    check("done_latency", cyc - c0, 65);
    check("busy_at_done", busy, 0);
    tick();
    check("done_one_cycle", done, 0);

    // backpressure: hold index 3 for 5 cycles
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(m_valid && m_index == 5'd3) && n < 40) begin tick(); n++; end
    check("bp_reached_idx3", m_index, 3);
    m_ready = 1'b0;
    repeat (5) tick();
    m_ready = 1'b1;
    wait_done(200);
    tick();

    // concurrent write to x5 while the read pointer is at 2
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (rf_r_address != 5'd2 && n < 40) begin tick(); n++; end
    check("cw_reached_ptr2", rf_r_address, 2);
    mem[5] = 32'h55;
    foreach (exp_q[k]) if (exp_q[k].idx == 5'd5) exp_q[k].data = 32'h55;
    wait_done(200);
    tick();

    // reset while a word is pending
    m_ready = 1'b0;
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!m_valid && n < 10) begin tick(); n++; end
    check("rst_mid_valid_seen", m_valid, 1);
    reset_n = 1'b0;
    exp_q.delete();
    dc = done_cnt;
    tick();
    check("abort_m_valid", m_valid, 0);
    check("abort_m_data", m_data, 0);
    check("abort_m_index", m_index, 0);
    check("abort_m_last", m_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset_n = 1'b1;
    m_ready = 1'b1;
    repeat (4) tick();
    check("abort_no_done", done_cnt - dc, 0);
    push_dump();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(100);
    tick();

    // three back-to-back dumps, start held high, random m_ready
    for (int i = 1; i < 32; i++) mem[i] = $urandom;
    repeat (3) push_dump();
    dc = done_cnt;
    start = 1'b1;
    n = 0;
    while ((done_cnt - dc) < 3 && n < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      if ((done_cnt - dc) == 2 && busy) start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    repeat (10) tick();
    check("rand_done_pulses", done_cnt - dc, 3);
    check("rand_idle_after", busy, 0);
    check("rand_queue_drained", exp_q.size(), 0);

    // single-register instance
    w2 = 0; d2 = 0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_valid2 && m_ready2) begin
        check("single_index", m_index2, 10);
        check("single_data", m_data2, 32'hDEADBEEF);
        check("single_last", m_last2, 1);
        w2++;
      end
      if (done2) d2++;
      tick();
    end
    check("single_word_count", w2, 1);
    check("single_done_count", d2, 1);
    check("single_idle", busy2, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
